truth_table_sweeper: RTL and testbench

- Sequential, synthesisable exhaustive-stimulus engine for small combinational blocks with N_IN single-bit inputs and one output.
- After a start pulse, it drives every input vector 0..2^N_IN-1 in order. Each vector is held for DWELL cycles.
- It captures the DUT output into a truth-table register, counts ones and compares against an expected table.
- Sits beside the DUT in lab top-levels and benches; replaces hand-written per-vector stimulus.

---
 rtl/truth_table_sweeper.sv | 142 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive-stimulus engine for a small combinational
// block with N_IN inputs and one output. It drives every input vector in
// order, holds each vector for DWELL cycles, samples the block's output on
// the last dwell cycle and builds a captured truth table. It also counts the
// ones it captured and compares the table against an expected one.
//
// Optional build macro: TTS_STOP_ON_FAIL_EN
//   defined   - the sweep ends at the first mismatching capture. vec_out stays
//               on the failing vector until FIN exits, and bits that were
//               never tested stay 0.
//   undefined - the full sweep always runs.
//
// Timing, with start accepted at edge E0:
//   - vector i is driven from E(i*DWELL) until E((i+1)*DWELL);
//   - vector i is captured at E((i+1)*DWELL);
//   - done is high in the cycle that follows the last capture edge (FIN);
//   - the FSM spends one IDLE cycle before it can accept the next start.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; results from the last sweep are held
// SWEEP | driving vectors, counting dwell cycles, capturing dut_out
// FIN   | done pulse cycle; vec_out returns to 0 on exit

module truth_table_sweeper #(
   parameter int N_IN  = 3,
   parameter int DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [(1<<N_IN)-1:0]  expect_tt,
   input  logic                  dut_out,
   output logic [N_IN-1:0]       vec_out,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<N_IN)-1:0]  truth,
   output logic [N_IN:0]         ones_cnt,
   output logic                  mismatch,
   output logic [N_IN-1:0]       fail_idx
);

   localparam int              NV         = 1 << N_IN;
   localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);
   localparam logic [N_IN-1:0] IDX_LAST   = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t          state;
   logic [NV-1:0]   exp_tt;
   logic [7:0]      dwell_cnt;
   logic            exp_bit;
   logic            miss;
   logic            last_vec;
   logic            stop_now;

   // vec_out doubles as the vector index, so the expected bit comes straight
   // from the table that was latched at start.
   assign exp_bit  = exp_tt[vec_out];
   assign miss     = dut_out != exp_bit;
   assign last_vec = vec_out == IDX_LAST;

`ifdef TTS_STOP_ON_FAIL_EN
   // The first mismatch ends the sweep. The mismatch flag cannot already be
   // set here, because any earlier miss would have stopped the sweep.
   assign stop_now = last_vec | miss;
`else
   assign stop_now = last_vec;
`endif

   // Sequencer: start handshake, vector stepping, capture/compare and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         exp_tt    <= '0;
         dwell_cnt <= '0;
         vec_out   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         truth     <= '0;
         ones_cnt  <= '0;
         mismatch  <= 1'b0;
         fail_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= SWEEP;
                  exp_tt    <= expect_tt;
                  truth     <= '0;
                  ones_cnt  <= '0;
                  mismatch  <= 1'b0;
                  fail_idx  <= '0;
                  vec_out   <= '0;
                  dwell_cnt <= '0;
                  busy      <= 1'b1;
               end
            end

            SWEEP: begin
               if (dwell_cnt == DWELL_LAST) begin
                  truth[vec_out] <= dut_out;
                  ones_cnt       <= ones_cnt + {{N_IN{1'b0}}, dut_out};
                  if (miss && !mismatch) begin
                     mismatch <= 1'b1;
                     fail_idx <= vec_out;
                  end
                  if (stop_now) begin
                     // vec_out is frozen on the last captured vector through FIN
                     state <= FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     vec_out   <= vec_out + 1'b1;
                     dwell_cnt <= '0;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + 8'd1;
               end
            end

            FIN: begin
               done    <= 1'b0;
               vec_out <= '0;
               state   <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. The block under sweep is modelled as a
// lookup table. Expected results come from the sweep rules: the captured
// table equals the function, ones come from a popcount, and the first
// mismatch is the lowest differing bit.
module tb_truth_table_sweeper;

   localparam int N  = 3;
   localparam int D  = 4;
   localparam int NV = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] expect_tt = 8'h00;
   logic       dut_out;
   logic [2:0] vec_out;
   logic       busy, done;
   logic [7:0] truth;
   logic [3:0] ones_cnt;
   logic       mismatch;
   logic [2:0] fail_idx;
   logic [7:0] func_tt = 8'h00;

   logic       start1 = 1'b0;
   logic [1:0] expect1 = 2'b01;
   logic       dut_out1;
   logic [0:0] vec1;
   logic       busy1, done1;
   logic [1:0] truth1;
   logic [1:0] ones1;
   logic       mm1;
   logic [0:0] fail1;

   int n_checks = 0;
   int n_fail   = 0;

   assign dut_out  = func_tt[vec_out];
   assign dut_out1 = ~vec1[0];

   always #5 clk = ~clk;

   truth_table_sweeper #(.N_IN(N), .DWELL(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .expect_tt(expect_tt),
      .dut_out(dut_out), .vec_out(vec_out), .busy(busy), .done(done),
      .truth(truth), .ones_cnt(ones_cnt), .mismatch(mismatch),
      .fail_idx(fail_idx)
   );

   truth_table_sweeper #(.N_IN(1), .DWELL(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .expect_tt(expect1),
      .dut_out(dut_out1), .vec_out(vec1), .busy(busy1), .done(done1),
      .truth(truth1), .ones_cnt(ones1), .mismatch(mm1), .fail_idx(fail1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int popc(input logic [7:0] v);
      int c = 0;
      for (int i = 0; i < 8; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_vec"},  vec_out,  0);
      chk({tag, "_busy"}, busy,     0);
      chk({tag, "_done"}, done,     0);
      chk({tag, "_tt"},   truth,    0);
      chk({tag, "_ones"}, ones_cnt, 0);
      chk({tag, "_mm"},   mismatch, 0);
      chk({tag, "_fidx"}, fail_idx, 0);
   endtask

   // One sweep. poke_k is the cycle where a stray start is raised (-1 for none).
   // rst_k is the cycle where reset aborts the sweep (-1 for none).
   task automatic run_sweep(input logic [7:0] f, input logic [7:0] e,
                            input int poke_k, input int rst_k);
      logic [7:0] diff, exp_tt;
      int fidx, end_k;
      logic exp_mm;
      diff   = f ^ e;
      exp_mm = diff != 0;
      fidx   = 0;
      for (int i = 7; i >= 0; i--) if (diff[i]) fidx = i;
      exp_tt = f;
      end_k  = NV * D;
`ifdef TTS_STOP_ON_FAIL_EN
      if (exp_mm) begin
         end_k  = (fidx + 1) * D;
         exp_tt = f & 8'((1 << (fidx + 1)) - 1);
      end
`endif
      func_tt   = f;
      expect_tt = e;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k <= end_k; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 2) expect_tt = ~e;
         if (k == poke_k) start = 1'b1;
         if (k == poke_k + 1) start = 1'b0;
         if (k == rst_k) begin
            rst_n = 1'b0;
            #1;
            chk_zero("abort");
            repeat (2) begin
               @(negedge clk);
               chk("abort_nodone", done, 0);
            end
            rst_n = 1'b1;
            return;
         end
         chk("vec", vec_out, (k < end_k) ? k / D : end_k / D - 1);
         chk("busy", busy, k < end_k);
         chk("done", done, k == end_k);
      end
      chk("truth", truth, exp_tt);
      chk("ones", ones_cnt, popc(exp_tt));
      chk("mismatch", mismatch, exp_mm);
      chk("fail_idx", fail_idx, exp_mm ? fidx : 0);
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_vec", vec_out, 0);
      chk("hold_truth", truth, exp_tt);
   endtask

   initial begin
      logic [7:0] f, e;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      chk("reset1_tt", truth1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_sweep(8'hE8, 8'hE8, -1, -1);
      run_sweep(8'hE8, 8'hE9, -1, -1);
      run_sweep(8'h96, 8'h96, 10, -1);
      run_sweep(8'h96, 8'h96, -1, 13);
      @(negedge clk);
      run_sweep(8'h96, 8'h96, -1, -1);

      for (int r = 0; r < 6; r++) begin
         f = 8'($urandom);
         e = (r % 2 == 0) ? f : (f ^ 8'(1 << $urandom_range(7, 0)));
         if (r == 5) e = 8'($urandom);
         run_sweep(f, e, (r == 3) ? 5 : -1, -1);
      end

      // N_IN=1, DWELL=1 inverter
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      for (int k = 0; k <= 2; k++) begin
         if (k > 0) @(negedge clk);
         chk("n1_vec", vec1, (k < 2) ? k : 1);
         chk("n1_done", done1, k == 2);
         chk("n1_busy", busy1, k < 2);
      end
      chk("n1_truth", truth1, 2'b01);
      chk("n1_ones", ones1, 1);
      chk("n1_mm", mm1, 0);

      // start held high: back-to-back sweeps with one IDLE cycle between
      func_tt   = 8'hE8;
      expect_tt = 8'hE8;
      @(negedge clk) start = 1'b1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         chk("b2b_done", done, (k == 32) || (k == 66));
         chk("b2b_busy", busy, (k < 32) || (k >= 34 && k < 66) || (k >= 68));
      end
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_zero("b2b_rst");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
